fifo_uart_tx: RTL and testbench

//   Drain stage behind the 16-bit sync FIFO: pops one word at a time and sends it as two 8N1 UART bytes.
//   The low byte goes first. Each byte is sent LSB first, with 1 start bit and 1 stop bit, no parity.

---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 123 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO drain stage and its surroundings.
// master: the UART drain stage. slave: the FIFO / board side.
interface fifo_uart_tx_if;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd_en;
    logic        txd;
    logic        busy;
    logic        word_done;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_rd_en, txd, busy, word_done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_rd_en, txd, busy, word_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one 16-bit word and sends it as two 8N1 UART bytes,
// low byte first, LSB first. txd and fifo_rd_en are registered and computed
// from the next-state values so they line up with state_q.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              sel_q, sel_d;
    logic [15:0]       word_q, word_d;
    logic              rd_en_q, rd_en_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic [7:0]        byte_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // State register and registered outputs; txd idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sel_q   <= 1'b0;
            word_q  <= '0;
            rd_en_q <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            rd_en_q <= rd_en_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sel_d   = sel_q;
        word_d  = word_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // enable / fifo_empty only matter here, so a word in flight
                // always completes regardless of what they do.
                if (bus.enable && !bus.fifo_empty) state_d = REQ;
            end
            REQ: state_d = LOAD;
            LOAD: begin
                // FIFO output is registered: valid the cycle after the pop.
                word_d  = bus.fifo_data;
                sel_d   = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!sel_q) begin
                        // High byte follows with no gap.
                        sel_d   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        byte_d  = sel_d ? word_d[15:8] : word_d[7:0];
        rd_en_d = (state_d == REQ);
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = byte_d[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.txd        = txd_q;
    assign bus.word_done  = done_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT, the txd
// line is recorded per cycle and compared with an ideal 8N1 waveform built
// from the words pushed.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int FRAME = 20 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fifo_uart_tx_if bus ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // FIFO model: words pushed by the tests, popped on fifo_rd_en.
    logic [15:0] mem[$];
    int wr_cnt = 0;
    int rd_ptr = 0;
    int pops = 0;
    int done_cnt = 0;
    bit noise_en = 1'b0;

    assign bus.fifo_empty = (rd_ptr == wr_cnt);

    // Registered FIFO read port; optional random noise on data when idle.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (rd_ptr < wr_cnt) begin
                bus.fifo_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
            pops <= pops + 1;
        end else if (noise_en) begin
            bus.fifo_data <= 16'($urandom);
        end
        if (bus.word_done) done_cnt <= done_cnt + 1;
    end

    int cmp = 0;
    int fail = 0;
    bit trace[0:511];
    bit exp_q[$];

    task automatic push(input logic [15:0] w);
        mem.push_back(w);
        wr_cnt++;
    endtask

    // Ideal line waveform for one word: two 8N1 bytes, low byte first.
    function automatic void add_frame(input logic [15:0] w);
        logic [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? w[7:0] : w[15:8];
            for (int j = 0; j < 10; j++)
                for (int c = 0; c < CPB; c++)
                    exp_q.push_back((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1]);
        end
    endfunction

    function automatic void add_gap(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    // Wait (bounded) for the first low cycle on txd; returns at that negedge.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Record n cycles of txd starting with the current cycle.
    task automatic capture(input int n, input int drop_at);
        trace[0] = bus.txd;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (i == drop_at) bus.enable = 1'b0;
            trace[i] = bus.txd;
        end
    endtask

    function automatic int count_bad(input int n, output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < n; i++)
            if (trace[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        return bad;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        cmp++; if (bus.txd !== 1'b1) begin fail++; $display("FAIL reset_txd: got %b want 1", bus.txd); end
        cmp++; if (bus.busy !== 1'b0) begin fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        cmp++; if (bus.fifo_rd_en !== 1'b0) begin fail++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        cmp++; if (bus.word_done !== 1'b0) begin fail++; $display("FAIL reset_word_done: got %b want 0", bus.word_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        bit ok; int bad, first, p0, d0;
        p0 = pops; d0 = done_cnt;
        push(16'hA55A);
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL single_start: no start bit within bound"); end
        capture(FRAME, -1);
        exp_q.delete(); add_frame(16'hA55A);
        bad = count_bad(FRAME, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL single_frame: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        @(negedge clk);
        cmp++; if (bus.word_done !== 1'b1) begin fail++; $display("FAIL single_word_done: got %b want 1 at START+80", bus.word_done); end
        cmp++; if (done_cnt != d0) begin fail++; $display("FAIL single_done_early: got %0d pulses want 0 before START+80", done_cnt - d0); end
        repeat (5) @(negedge clk);
        cmp++; if (pops - p0 != 1) begin fail++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    endtask

    task automatic test_back_to_back;
        bit ok; int bad, first, p0;
        logic [7:0] got;
        int base[4] = '{0, 40, FRAME + 3, FRAME + 43};
        logic [7:0] want[4] = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        bus.enable = 1'b0;
        @(negedge clk);
        p0 = pops;
        push(16'h0001); push(16'hFFFF);
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL b2b_start: no start bit within bound"); end
        capture(2 * FRAME + 3, -1);
        exp_q.delete(); add_frame(16'h0001); add_gap(3); add_frame(16'hFFFF);
        bad = count_bad(2 * FRAME + 3, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL b2b_frame_gap: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) got[j] = trace[base[k] + (1 + j) * CPB + CPB / 2];
            cmp++; if (got !== want[k]) begin fail++; $display("FAIL b2b_byte%0d: got %h want %h", k, got, want[k]); end
        end
        repeat (5) @(negedge clk);
        cmp++; if (pops - p0 != 2) begin fail++; $display("FAIL b2b_pops: got %0d want 2", pops - p0); end
    endtask

    task automatic test_empty;
        int v_rd = 0, v_txd = 0, v_busy = 0;
        bus.enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en !== 1'b0) v_rd++;
            if (bus.txd !== 1'b1) v_txd++;
            if (bus.busy !== 1'b0) v_busy++;
        end
        cmp++; if (v_rd != 0) begin fail++; $display("FAIL empty_rd_en: %0d cycles high, want 0", v_rd); end
        cmp++; if (v_txd != 0) begin fail++; $display("FAIL empty_txd: %0d cycles low, want 0", v_txd); end
        cmp++; if (v_busy != 0) begin fail++; $display("FAIL empty_busy: %0d cycles busy, want 0", v_busy); end
    endtask

    task automatic test_enable_drop;
        bit ok; int bad, first, p0;
        logic [15:0] w[3];
        bus.enable = 1'b0;
        @(negedge clk);
        p0 = pops;
        for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); push(w[i]); end
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL drop_start: no start bit within bound"); end
        capture(FRAME, $urandom_range(1, 35));
        exp_q.delete(); add_frame(w[0]);
        bad = count_bad(FRAME, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL drop_frame: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        repeat (60) @(negedge clk);
        cmp++; if (pops - p0 != 1) begin fail++; $display("FAIL drop_pops: got %0d want 1", pops - p0); end
        cmp++; if (bus.busy !== 1'b0 || bus.txd !== 1'b1) begin fail++; $display("FAIL drop_idle: busy %b txd %b want 0/1", bus.busy, bus.txd); end
        bus.enable = 1'b1;
        @(negedge clk);
        cmp++; if (bus.fifo_rd_en !== 1'b1) begin fail++; $display("FAIL drop_repop: rd_en %b want 1 one cycle after enable", bus.fifo_rd_en); end
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL drop_restart: no start bit within bound"); end
        capture(2 * FRAME + 3, -1);
        exp_q.delete(); add_frame(w[1]); add_gap(3); add_frame(w[2]);
        bad = count_bad(2 * FRAME + 3, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL drop_rest: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_data_isolation;
        bit ok; int bad, first, n;
        logic [15:0] w[4];
        bus.enable = 1'b0;
        noise_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin w[i] = 16'($urandom); push(w[i]); end
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL iso_start: no start bit within bound"); end
        n = 4 * FRAME + 9;
        capture(n, -1);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin add_frame(w[i]); if (i < 3) add_gap(3); end
        bad = count_bad(n, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL iso_frames: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        noise_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        bit ok; int bad, first, p0, d0, v_txd, v_busy;
        logic [15:0] w;
        bus.enable = 1'b0;
        @(negedge clk);
        push(16'($urandom));
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL rstmid_start: no start bit within bound"); end
        repeat (4 + $urandom_range(0, 28)) @(negedge clk);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        cmp++; if (bus.txd !== 1'b1) begin fail++; $display("FAIL rstmid_txd: got %b want 1", bus.txd); end
        cmp++; if (bus.busy !== 1'b0) begin fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        cmp++; if (bus.fifo_rd_en !== 1'b0) begin fail++; $display("FAIL rstmid_rd_en: got %b want 0", bus.fifo_rd_en); end
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        p0 = pops; v_txd = 0; v_busy = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1) v_txd++;
            if (bus.busy !== 1'b0) v_busy++;
        end
        cmp++; if (done_cnt != d0) begin fail++; $display("FAIL rstmid_word_done: got %0d pulses want 0", done_cnt - d0); end
        cmp++; if (v_txd != 0 || v_busy != 0 || pops != p0) begin fail++; $display("FAIL rstmid_idle: txd-low %0d busy %0d pops %0d, want 0/0/0", v_txd, v_busy, pops - p0); end
        w = 16'($urandom);
        push(w);
        bus.enable = 1'b1;
        wait_start(ok);
        cmp++; if (!ok) begin fail++; $display("FAIL rstmid_restart: no start bit within bound"); end
        capture(FRAME, -1);
        exp_q.delete(); add_frame(w);
        bad = count_bad(FRAME, first);
        cmp++; if (bad != 0) begin fail++; $display("FAIL rstmid_next_word: %0d bad samples, first at %0d, want 0 bad", bad, first); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_enable_drop();
        test_data_isolation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
